// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol stream into the frame controller and the decoded-bit stream out of it.
// master = symbol source / bit sink, slave = viterbi_frame_ctrl.
interface viterbi_frame_ctrl_if;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       sym_ready;
  logic       bit_valid;
  logic [1:0] bit_data;

  modport master (
    output sym_valid,
    output sym_data,
    input  sym_ready,
    input  bit_valid,
    input  bit_data
  );

  modport slave (
    input  sym_valid,
    input  sym_data,
    output sym_ready,
    output bit_valid,
    output bit_data
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the 2-bit-symbol Viterbi datapath: weight registers,
// symbol intake, tail flush and decoded-bit return.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; config writes accepted; datapath in reset
// S_INIT  | one cycle, datapath held in reset, step counter cleared
// S_RUN   | one step per accepted payload symbol, stalls without sym_valid
// S_FLUSH | one zero tail symbol per cycle, TAIL_LEN cycles
// S_DRAIN | one cycle, frame_done asserted
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int TAIL_LEN  = 2,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_addr,
  input  logic [1:0]                cfg_data,
  viterbi_frame_ctrl_if.slave       strm,
  output logic                      dp_rst,
  output logic                      dp_ce,
  output logic [1:0]                dec_in,
  output logic                      sel0,
  output logic [1:0]                sel1,
  output logic [1:0]                w0_00,
  output logic [1:0]                w0_01,
  output logic [1:0]                w1_10,
  output logic [1:0]                w1_11,
  output logic [1:0]                w2_00,
  output logic [1:0]                w2_01,
  output logic [1:0]                w3_10,
  output logic [1:0]                w3_11,
  input  logic [1:0]                dp_out,
  output logic                      busy,
  output logic                      frame_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_SYM  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(FRAME_LEN + TAIL_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] step, step_nxt;
  logic             do_step;
  logic             sel0_nxt;
  logic [1:0]       sel1_nxt;
  logic [1:0]       wreg [8];
  logic             bit_valid_q;
  logic [1:0]       bit_data_q;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    do_step   = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_INIT;
      S_INIT: begin
        step_nxt  = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (strm.sym_valid) begin
          do_step  = 1'b1;
          step_nxt = step + CNT_W'(1);
          if (step == LAST_SYM) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        do_step  = 1'b1;
        step_nxt = step + CNT_W'(1);
        if (step == LAST_STEP) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Select schedule is keyed on the index of the step being issued.
  always_comb begin
    sel0_nxt = 1'b1;
    sel1_nxt = 2'b10;
    if (step == '0) begin
      sel0_nxt = 1'b0;
      sel1_nxt = 2'b00;
    end else if (step < CNT_W'(3)) begin
      sel0_nxt = 1'b0;
      sel1_nxt = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      step        <= '0;
      dec_in      <= 2'b00;
      sel0        <= 1'b0;
      sel1        <= 2'b00;
      dp_ce       <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 2'b00;
    end else begin
      state       <= state_nxt;
      step        <= step_nxt;
      dp_ce       <= do_step;
      bit_valid_q <= dp_ce;
      if (dp_ce) bit_data_q <= dp_out;
      if (do_step) begin
        dec_in <= (state == S_RUN) ? strm.sym_data : 2'b00;
        sel0   <= sel0_nxt;
        sel1   <= sel1_nxt;
      end
    end
  end

  // Weights only change in IDLE, so they are stable for the whole frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) wreg[i] <= 2'b00;
    end else if (state == S_IDLE && cfg_we) begin
      wreg[cfg_addr] <= cfg_data;
    end
  end

  assign w0_00 = wreg[0];
  assign w0_01 = wreg[1];
  assign w1_10 = wreg[2];
  assign w1_11 = wreg[3];
  assign w2_00 = wreg[4];
  assign w2_01 = wreg[5];
  assign w3_10 = wreg[6];
  assign w3_11 = wreg[7];

  assign dp_rst         = (state == S_IDLE) || (state == S_INIT);
  assign busy           = (state != S_IDLE);
  assign frame_done     = (state == S_DRAIN);
  assign strm.sym_ready = (state == S_RUN);
  assign strm.bit_valid = bit_valid_q;
  assign strm.bit_data  = bit_data_q;

endmodule
